// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes straight from a flop, so back-pressure never forms a combinational
// path from out_ready to in_ready. A synchronous flush turns held beats into bubbles,
// and a saturating counter reports how many valid beats were discarded.
module pipe_stage_skid #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 16,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    // Main entry drives the outputs; skid entry catches the beat that arrives
    // while the consumer is stalled.
    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              xfer_in;
    logic              xfer_out;
    logic [1:0]        drop_inc;

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
        if (sum > {2'b00, {CNT_W{1'b1}}})
            return {CNT_W{1'b1}};
        else
            return sum[CNT_W-1:0];
    endfunction

    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;
    assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign drop_cnt  = drop_cnt_q;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = m_valid_q & out_ready;

    // Beats lost on a flush: an unreleased main beat, any skid beat, and the
    // beat that would have been accepted this cycle.
    assign drop_inc = {1'b0, m_valid_q & !xfer_out} + {1'b0, s_valid_q} + {1'b0, xfer_in};

    // Next-state selection: flush first, then the EMPTY/FULL/SKID handshake moves.
    always_comb begin
        m_valid_d  = m_valid_q;
        s_valid_d  = s_valid_q;
        m_data_d   = m_data_q;
        s_data_d   = s_data_q;
        m_ctrl_d   = m_ctrl_q;
        s_ctrl_d   = s_ctrl_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            m_valid_d  = 1'b0;
            s_valid_d  = 1'b0;
            m_ctrl_d   = '0;
            s_ctrl_d   = '0;
            if (CLEAR_DATA != 0) begin
                m_data_d = '0;
                s_data_d = '0;
            end
            drop_cnt_d = sat_add(drop_cnt_q, drop_inc);
        end else if (!m_valid_q) begin
            // EMPTY: an accepted beat goes straight to the output entry.
            if (xfer_in) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end
        end else if (!s_valid_q) begin
            // FULL: pass through on release, park in skid on stall.
            if (xfer_in && xfer_out) begin
                m_data_d = in_data;
                m_ctrl_d = in_ctrl;
            end else if (xfer_in) begin
                s_valid_d = 1'b1;
                s_data_d  = in_data;
                s_ctrl_d  = in_ctrl;
            end else if (xfer_out) begin
                m_valid_d = 1'b0;
            end
        end else begin
            // SKID: input is closed; promote the skid beat once main drains.
            if (xfer_out) begin
                m_data_d  = s_data_q;
                m_ctrl_d  = s_ctrl_q;
                s_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset clears every entry and the drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            m_data_q   <= '0;
            s_data_q   <= '0;
            m_ctrl_q   <= '0;
            s_ctrl_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            m_data_q   <= m_data_d;
            s_data_q   <= s_data_d;
            m_ctrl_q   <= m_ctrl_d;
            s_ctrl_q   <= s_ctrl_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a vector table for the handshake and flush
// cases, plus hand-written sequences for drop-counter saturation, data clearing
// on flush and asynchronous reset in the middle of a cycle.
module tb_pipe_stage_skid;

    localparam logic [63:0] D0 = 64'h1111_1111_1111_1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;

    // Instance A: default parameters.
    logic        a_ird, a_ov;
    logic [63:0] a_od;
    logic [15:0] a_oc;
    logic [1:0]  a_occ;
    logic [7:0]  a_drop;

    // Instance B: data cleared on flush, 2-bit drop counter.
    logic        b_ird, b_ov;
    logic [63:0] b_od;
    logic [15:0] b_oc;
    logic [1:0]  b_occ;
    logic [1:0]  b_drop;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(16), .CLEAR_DATA(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_ird), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od), .out_ctrl(a_oc),
        .occupancy(a_occ), .drop_cnt(a_drop)
    );

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(16), .CLEAR_DATA(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_ird), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od), .out_ctrl(b_oc),
        .occupancy(b_occ), .drop_cnt(b_drop)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] d;
        logic [15:0] c;
        logic        ordy;
        logic        e_ird;
        logic        e_ov;
        logic [63:0] e_od;
        logic [15:0] e_oc;
        logic [1:0]  e_occ;
        logic [7:0]  e_drop;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    function automatic vec_t mk(logic fl, logic iv, logic [63:0] d, logic [15:0] c,
                                logic ordy, logic e_ird, logic e_ov, logic [63:0] e_od,
                                logic [15:0] e_oc, logic [1:0] e_occ, logic [7:0] e_drop);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
        v.e_ird = e_ird; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc;
        v.e_occ = e_occ; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [63:0] d,
                         input logic [15:0] c, input logic ordy);
        flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic ird, input logic ov,
                         input logic [63:0] od, input logic [15:0] oc,
                         input logic [1:0] occ, input logic [7:0] drop);
        n_vec++;
        chk({tag, ".in_ready"},  64'(a_ird),  64'(ird));
        chk({tag, ".out_valid"}, 64'(a_ov),   64'(ov));
        chk({tag, ".out_data"},  a_od,        od);
        chk({tag, ".out_ctrl"},  64'(a_oc),   64'(oc));
        chk({tag, ".occupancy"}, 64'(a_occ),  64'(occ));
        chk({tag, ".drop_cnt"},  64'(a_drop), 64'(drop));
    endtask

    task automatic do_reset();
        drive(0, 0, '0, '0, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, '0, '0, 0);

        // Vector table: each row is the input for one edge and the state after it.
        tbl[0]  = mk(0, 1, D0,        16'h00A5, 1,  1, 1, D0,        16'h00A5, 1, 0);
        tbl[1]  = mk(0, 1, D0 + 1,    16'h00A5, 1,  1, 1, D0 + 1,    16'h00A5, 1, 0);
        tbl[2]  = mk(0, 1, D0 + 2,    16'h00A5, 1,  1, 1, D0 + 2,    16'h00A5, 1, 0);
        tbl[3]  = mk(0, 1, D0 + 3,    16'h00A5, 1,  1, 1, D0 + 3,    16'h00A5, 1, 0);
        tbl[4]  = mk(0, 0, 64'h0,     16'h0000, 1,  1, 0, D0 + 3,    16'h00A5, 0, 0);
        tbl[5]  = mk(0, 1, 64'hAA,    16'h0011, 0,  1, 1, 64'hAA,    16'h0011, 1, 0);
        tbl[6]  = mk(0, 1, 64'hBB,    16'h0022, 0,  0, 1, 64'hAA,    16'h0011, 2, 0);
        tbl[7]  = mk(0, 1, 64'hCC,    16'h0033, 0,  0, 1, 64'hAA,    16'h0011, 2, 0);
        tbl[8]  = mk(0, 0, 64'h0,     16'h0000, 1,  1, 1, 64'hBB,    16'h0022, 1, 0);
        tbl[9]  = mk(0, 0, 64'h0,     16'h0000, 1,  1, 0, 64'hBB,    16'h0022, 0, 0);
        tbl[10] = mk(0, 1, 64'hAA,    16'h0011, 0,  1, 1, 64'hAA,    16'h0011, 1, 0);
        tbl[11] = mk(0, 1, 64'hBB,    16'h0022, 0,  0, 1, 64'hAA,    16'h0011, 2, 0);
        tbl[12] = mk(1, 1, 64'hCC,    16'h0033, 0,  1, 0, 64'hAA,    16'h0000, 0, 2);
        tbl[13] = mk(0, 1, 64'hDD,    16'h0044, 0,  1, 1, 64'hDD,    16'h0044, 1, 2);
        tbl[14] = mk(1, 1, 64'hEE,    16'h0055, 1,  1, 0, 64'hDD,    16'h0000, 0, 3);
        tbl[15] = mk(1, 0, 64'h0,     16'h0000, 1,  1, 0, 64'hDD,    16'h0000, 0, 3);
        tbl[16] = mk(0, 1, 64'hFF,    16'h0066, 1,  1, 1, 64'hFF,    16'h0066, 1, 3);

        // Reset values, observed while rst_n is still low.
        do_reset();
        rst_n = 1'b0;
        #1;
        chk_a("reset", 1, 0, 64'h0, 16'h0, 0, 8'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
            tick();
            chk_a($sformatf("vec%0d", i), tbl[i].e_ird, tbl[i].e_ov, tbl[i].e_od,
                  tbl[i].e_oc, tbl[i].e_occ, tbl[i].e_drop);
        end

        // Drop counter saturation: five flushes, each killing one held beat.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 64'(i + 1), 16'h0001, 0);
            tick();
            drive(1, 0, '0, '0, 0);
            tick();
            n_vec++;
            chk($sformatf("sat%0d.drop_a", i), 64'(a_drop), 64'(i + 1));
            chk($sformatf("sat%0d.drop_b", i), 64'(b_drop), (i >= 2) ? 64'd3 : 64'(i + 1));
        end

        // Flush in SKID with data clearing enabled on instance B.
        do_reset();
        drive(0, 1, 64'hAA, 16'h0011, 0);
        tick();
        drive(0, 1, 64'hBB, 16'h0022, 0);
        tick();
        drive(1, 1, 64'hCC, 16'h0033, 0);
        tick();
        n_vec++;
        chk("clr.b_out_data",  b_od,          64'h0);
        chk("clr.b_out_valid", 64'(b_ov),     64'h0);
        chk("clr.b_out_ctrl",  64'(b_oc),     64'h0);
        chk("clr.b_occupancy", 64'(b_occ),    64'h0);
        chk("clr.b_in_ready",  64'(b_ird),    64'h1);
        chk("clr.b_drop_cnt",  64'(b_drop),   64'h2);
        chk("clr.a_out_data",  a_od,          64'hAA);

        // Refill to SKID, then reset asynchronously between edges.
        drive(0, 1, 64'hDD, 16'h0044, 0);
        tick();
        drive(0, 1, 64'hEE, 16'h0055, 0);
        tick();
        chk_a("skid2", 0, 1, 64'hDD, 16'h0044, 2, 8'h2);
        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 1, 0, 64'h0, 16'h0, 0, 8'h0);
        n_vec++;
        chk("async_rst.b_drop", 64'(b_drop), 64'h0);
        chk("async_rst.b_occ",  64'(b_occ),  64'h0);
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release accepts immediately.
        drive(0, 1, 64'h1234, 16'h0077, 1);
        tick();
        chk_a("post_rst", 1, 1, 64'h1234, 16'h0077, 1, 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
